// File: rtl/video_stream_writer.sv
// video_stream_writer: bridges a Wishbone pixel stream into the SDRAM frame buffer through a small FIFO.
// The master side writes each buffered pixel at BASE_ADR + 4*index; a start-of-frame word restarts the index.
module video_stream_writer #(
    parameter int          HDISP    = 800,
    parameter int          VDISP    = 480,
    parameter logic [31:0] BASE_ADR = 32'h0,
    parameter int          DEPTH    = 16
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      s_cyc,
    input  logic                      s_stb,
    input  logic                      s_we,
    input  logic [31:0]               s_adr,
    input  logic [31:0]               s_dat_ms,
    input  logic [3:0]                s_sel,
    output logic                      s_ack,
    output logic                      s_err,
    output logic [31:0]               s_dat_sm,
    output logic                      m_cyc,
    output logic                      m_stb,
    output logic                      m_we,
    output logic [31:0]               m_adr,
    output logic [31:0]               m_dat_ms,
    output logic [3:0]                m_sel,
    output logic [2:0]                m_cti,
    output logic [1:0]                m_bte,
    input  logic                      m_ack,
    input  logic                      m_err,
    output logic                      frame_done,
    output logic                      wr_err,
    output logic [$clog2(DEPTH):0]    fifo_level
);
    localparam int NPIX = HDISP * VDISP;
    localparam int IW = $clog2(NPIX);
    localparam int AW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(NPIX - 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0] state;
    logic [32:0] mem [DEPTH];
    logic [32:0] head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [IW-1:0] pix_idx, cur_idx, next_pix, pop_idx;
    logic full, empty, push, pop, term;

    assign s_dat_sm = '0;
    assign m_sel = 4'hF;
    assign m_cti = 3'b000;
    assign m_bte = 2'b00;
    assign m_cyc = state == WRITE;
    assign m_stb = state == WRITE;
    assign m_we = state == WRITE;

    assign fifo_level = wr_ptr - rd_ptr;
    assign full = fifo_level == (AW + 1)'(DEPTH);
    assign empty = fifo_level == '0;
    assign push = s_cyc & s_stb & s_we & !full & !s_ack;
    assign term = (state == WRITE) & (m_ack | m_err);
    assign pop = !empty & ((state == IDLE) | term);
    assign head = mem[rd_ptr[AW-1:0]];
    // A pop in the termination cycle must already see the advanced index.
    assign next_pix = term ? ((cur_idx == LAST) ? '0 : cur_idx + IW'(1)) : pix_idx;
    assign pop_idx = head[32] ? '0 : next_pix;

    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {s_adr == 32'd0, s_dat_ms};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            s_ack      <= 1'b0;
            s_err      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pix_idx    <= '0;
            cur_idx    <= '0;
            m_adr      <= '0;
            m_dat_ms   <= '0;
            frame_done <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            s_ack      <= push;
            s_err      <= s_cyc & s_stb & !s_we & !s_err;
            wr_ptr     <= wr_ptr + (AW + 1)'(push);
            rd_ptr     <= rd_ptr + (AW + 1)'(pop);
            pix_idx    <= next_pix;
            frame_done <= term & (cur_idx == LAST);
            if (term & m_err) wr_err <= 1'b1;
            if (pop) begin
                state    <= WRITE;
                cur_idx  <= pop_idx;
                m_adr    <= BASE_ADR + (32'(pop_idx) << 2);
                m_dat_ms <= head[31:0];
            end else if (term) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_video_stream_writer.sv
// tb_video_stream_writer: random and directed stimulus with a queue scoreboard and a frame-index reference model.
module tb_video_stream_writer;
    localparam int HD = 4;
    localparam int VD = 2;
    localparam int NP = HD * VD;
    localparam int DEPTH = 4;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic sys_clk, sys_rst_n;
    logic s_cyc, s_stb, s_we, s_ack, s_err;
    logic [31:0] s_adr, s_dat_ms, s_dat_sm;
    logic [3:0] s_sel;
    logic m_cyc, m_stb, m_we, m_ack, m_err;
    logic [31:0] m_adr, m_dat_ms;
    logic [3:0] m_sel;
    logic [2:0] m_cti;
    logic [1:0] m_bte;
    logic frame_done, wr_err;
    logic [$clog2(DEPTH):0] fifo_level;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        bit          last;
    } exp_t;

    exp_t q[$];
    int total = 0, bad = 0;
    int mpix = 0, ack_cnt = 0, term_cnt = 0, wcnt = 0;
    int mode = 0, err_at = -1;
    bit err_en = 0, fd_next = 0, err_seen = 0, prev_ack = 0;

    video_stream_writer #(.HDISP(HD), .VDISP(VD), .BASE_ADR(BASE), .DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms), .s_sel(s_sel),
        .s_ack(s_ack), .s_err(s_err), .s_dat_sm(s_dat_sm),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_ms(m_dat_ms),
        .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte), .m_ack(m_ack), .m_err(m_err),
        .frame_done(frame_done), .wr_err(wr_err), .fifo_level(fifo_level)
    );

    initial sys_clk = 0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    function automatic logic [31:0] rand_adr();
        return 32'($urandom_range(1, 1000)) << 2;
    endfunction

    // Reference model: index restarts at 0 on sof, otherwise follows the previous word modulo NP.
    task automatic write_word(input logic [31:0] adr, input logic [31:0] dat);
        bit got = 0;
        int idx;
        @(posedge sys_clk);
        #1;
        s_cyc = 1; s_stb = 1; s_we = 1; s_adr = adr; s_dat_ms = dat;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge sys_clk);
            got = s_ack;
        end
        s_cyc = 0; s_stb = 0;
        if (!got) chk("s_ack_timeout", 0, 1);
        else begin
            idx = (adr == 0) ? 0 : mpix;
            q.push_back('{BASE + 32'(idx) * 4, dat, idx == NP - 1});
            mpix = (idx + 1) % NP;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000; i++) begin
            @(negedge sys_clk);
            if (q.size() == 0 && !m_cyc) break;
        end
        chk("drain_queue", 32'(q.size()), 0);
        chk("drain_level", 32'(fifo_level), 0);
    endtask

    // SDRAM responder: mode 0 never ends, 1 acks at once, 2 after 3 waits, 3 random.
    initial begin
        bit go, e;
        m_ack = 0; m_err = 0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (!sys_rst_n || !m_stb) begin
                m_ack = 0; m_err = 0; wcnt = 0;
            end else begin
                wcnt = (m_ack | m_err) ? 1 : wcnt + 1;
                go = (mode == 1) || (mode == 2 && wcnt == 4) || (mode == 3 && $urandom_range(0, 2) == 0);
                e = go && (term_cnt == err_at || (err_en && $urandom_range(0, 4) == 0));
                m_ack = go && !e;
                m_err = go && e;
                if (go) term_cnt++;
            end
        end
    end

    // Monitor / scoreboard
    initial forever begin
        exp_t x;
        @(negedge sys_clk);
        if (sys_rst_n) begin
            chk("frame_done", 32'(frame_done), 32'(fd_next));
            chk("wr_err", 32'(wr_err), 32'(err_seen));
            if (s_ack) begin
                ack_cnt++;
                chk("s_ack_width", 32'(prev_ack), 0);
            end
            prev_ack = s_ack;
            fd_next = 0;
            if (m_cyc && m_stb && (m_ack || m_err)) begin
                if (q.size() == 0) chk("unexpected_write", m_adr, 32'hFFFF_FFFF);
                else begin
                    x = q.pop_front();
                    chk("m_adr", m_adr, x.adr);
                    chk("m_dat_ms", m_dat_ms, x.dat);
                    chk("m_we", 32'(m_we), 1);
                    chk("m_sel", 32'(m_sel), 32'hF);
                    fd_next = x.last;
                end
                if (m_err) err_seen = 1;
            end
        end
    end

    initial begin
        int a0;
        sys_rst_n = 0; s_cyc = 0; s_stb = 0; s_we = 0; s_adr = 0; s_dat_ms = 0; s_sel = 4'hF;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_m_cyc", 32'(m_cyc), 0);
        chk("rst_m_stb", 32'(m_stb), 0);
        chk("rst_s_ack", 32'(s_ack), 0);
        chk("rst_s_err", 32'(s_err), 0);
        chk("rst_m_adr", m_adr, 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_m_sel", 32'(m_sel), 32'hF);
        chk("rst_m_cti", 32'(m_cti), 0);
        chk("rst_m_bte", 32'(m_bte), 0);
        chk("rst_s_dat_sm", s_dat_sm, 0);
        sys_rst_n = 1;

        mode = 2;
        write_word(0, 32'hA5A5_A5A5);
        @(negedge sys_clk);
        chk("latency_m_stb", 32'(m_stb), 1);
        chk("single_m_adr", m_adr, BASE);
        chk("single_m_dat", m_dat_ms, 32'hA5A5_A5A5);
        wait_idle();

        mode = 1;
        for (int i = 0; i < 5; i++) write_word(32'(i * 4), $urandom);
        wait_idle();

        mode = 0;
        a0 = ack_cnt;
        fork
            for (int i = 0; i < DEPTH + 2; i++) write_word(rand_adr(), $urandom);
            begin
                repeat (40) @(negedge sys_clk);
                chk("full_acks", 32'(ack_cnt - a0), DEPTH + 1);
                chk("full_level", 32'(fifo_level), DEPTH);
                mode = 1;
                @(posedge sys_clk);
                for (int i = 0; i < DEPTH + 1; i++) begin
                    @(negedge sys_clk);
                    chk("b2b_m_stb", 32'(m_stb), 1);
                end
            end
        join
        wait_idle();

        for (int i = 0; i < 9; i++) write_word(i == 0 ? 0 : rand_adr(), $urandom);
        wait_idle();

        for (int i = 0; i < 3; i++) write_word(rand_adr(), $urandom);
        write_word(0, 32'h5050_0505);
        wait_idle();

        err_at = term_cnt + 1;
        write_word(0, $urandom);
        write_word(rand_adr(), $urandom);
        write_word(rand_adr(), $urandom);
        wait_idle();
        err_at = -1;
        chk("wr_err_sticky", 32'(wr_err), 1);

        a0 = ack_cnt;
        @(posedge sys_clk);
        #1;
        s_cyc = 1; s_stb = 1; s_we = 0;
        @(posedge sys_clk);
        #1;
        s_cyc = 0; s_stb = 0;
        @(negedge sys_clk);
        chk("read_s_err", 32'(s_err), 1);
        chk("read_level", 32'(fifo_level), 0);
        @(negedge sys_clk);
        chk("read_s_err_drop", 32'(s_err), 0);
        chk("read_no_ack", 32'(ack_cnt - a0), 0);

        mode = 3; err_en = 1;
        for (int i = 0; i < 60; i++) begin
            write_word($urandom_range(0, 7) == 0 ? 0 : rand_adr(), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge sys_clk);
        end
        err_en = 0; mode = 1;
        wait_idle();

        mode = 0;
        write_word(rand_adr(), $urandom);
        repeat (3) @(negedge sys_clk);
        #2;
        sys_rst_n = 0;
        #1;
        chk("arst_m_cyc", 32'(m_cyc), 0);
        chk("arst_m_stb", 32'(m_stb), 0);
        chk("arst_m_adr", m_adr, 0);
        chk("arst_wr_err", 32'(wr_err), 0);
        chk("arst_level", 32'(fifo_level), 0);
        q.delete();
        mpix = 0; fd_next = 0; err_seen = 0; prev_ack = 0;
        @(negedge sys_clk);
        sys_rst_n = 1;
        mode = 1;
        write_word(rand_adr(), 32'h1234_5678);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
